rotary_decoder: RTL and testbench
=================================

// Module: rotary_decoder
// PURPOSE
//  Front end for the rotary-encoder/WS2812B design. Samples the raw quadrature (A/B) and push-button pins of the
//  mechanical encoder, then synchronises and debounces them. Decodes the Gray-code rotation and emits one-cycle
//  rot_up / rot_dn / push pulses for the LED controller. Runs on the 40 MHz system clock.
// PARAMETERS
//  SYNC_STAGES      2      synchroniser flops per input (>=2)
//  DEBOUNCE_CYCLES  40000  consecutive stable cycles before a debounced level changes (1 ms @ 40 MHz; >=2)
//  STEPS_PER_PULSE  4      valid quadrature steps per rot_up/rot_dn pulse (1, 2 or 4)
// PORTS
//  clk      in   1  system clock, 40 MHz
//  res      in   1  reset, asynchronous, active-high
//  enc_a    in   1  raw encoder channel A (async, bouncy)
//  enc_b    in   1  raw encoder channel B (async, bouncy)
//  enc_btn  in   1  raw push button, active-high (async, bouncy)
//  rot_up   out  1  one-cycle pulse per STEPS_PER_PULSE clockwise steps
//  rot_dn   out  1  one-cycle pulse per STEPS_PER_PULSE counter-clockwise steps
//  push     out  1  one-cycle pulse on debounced button press
//  err_cnt  out  8  illegal-transition count (present only with ROT_ERR_CNT_EN)
// BEHAVIOUR
//  - Clock: single clock clk. Reset: res is asynchronous and active-high. All flops clear asynchronously.
//  - Reset values: A/B sync flops and debounced A/B = 1 (detent 2'b11). Button sync/debounced = 0.
//    Debounce counters = 0, step accumulator = 0. rot_up = rot_dn = push = 0, err_cnt = 0.
//  - Sync: each pin passes through SYNC_STAGES flops. No logic is placed between the stages.
//  - Debounce (per input, independent): a counter of width $clog2(DEBOUNCE_CYCLES) is kept.
//    . synced == stable: counter <= 0.
//    . synced != stable and counter < DEBOUNCE_CYCLES-1: counter += 1.
//    . synced != stable and counter == DEBOUNCE_CYCLES-1: stable <= synced, counter <= 0.
//    . Any glitch shorter than DEBOUNCE_CYCLES cycles is fully rejected.
//  - Quadrature: prev <= {stable_a, stable_b} every cycle. CW order: 00->01->11->10->00.
//    . CW step: acc += 1. CCW step: acc -= 1. No change: hold.
//    . Illegal step (both bits flip): acc <= 0, no pulse, error event.
//    . acc is signed, 4 bits. Reaching +STEPS_PER_PULSE: rot_up = 1 for one cycle, acc <= 0.
//      Reaching -STEPS_PER_PULSE: rot_dn = 1 for one cycle, acc <= 0.
//    . A direction reversal mid-detent just decrements/increments, so partial turns cancel.
//  - Push: push = 1 for exactly one cycle on a 0->1 transition of the debounced button. Nothing on release.
//    Holding the button produces no repeat pulses.
//  - Outputs are registered. rot_up and rot_dn are never high together. push may coincide with either.
//  - Latency, pin edge to pulse (input held stable): SYNC_STAGES + DEBOUNCE_CYCLES + 1 clk cycles.
//  - Back-to-back steps closer than DEBOUNCE_CYCLES are absorbed by debounce. This is by design.
//  - res asserted mid-rotation: acc clears and no pulse is emitted.
//    After release, the first change is judged against the reset state 2'b11.
//    If the pins rest elsewhere, that first debounced change is decoded normally.
//    A two-bit difference counts as illegal.
// CONFIGURATION
//  ROT_ERR_CNT_EN defined:
//    - err_cnt port exists. It is an 8-bit counter that increments on each illegal quadrature step.
//    - It saturates at 255 and clears only on res.
//  ROT_ERR_CNT_EN undefined:
//    - err_cnt port and counter are removed.
//    - Illegal steps still clear acc silently.
// TESTING (bench: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, STEPS_PER_PULSE=4)
//  1. Reset: assert res with inputs X, then release with A=B=1, btn=0.
//     -> All outputs 0, err_cnt=0. No pulse for 20 cycles.
//  2. CW detent: drive AB 11->10->00->01->11, each held 10 cycles.
//     -> Exactly one rot_up pulse, 7 cycles after the final edge. rot_dn stays 0.
//  3. CCW detent: drive AB 11->01->00->10->11.
//     -> Exactly one rot_dn pulse. Then half-CW + half-CCW (11->10->00->10->11) -> no pulse.
//  4. Bounce: toggle A for 3 cycles, then return.
//     -> Debounced A unchanged, no pulse. Hold A low for 4 cycles -> debounced A flips.
//  5. Illegal: drive AB 11->00 in one edge, hold 10 cycles.
//     -> No pulse, acc=0. With ROT_ERR_CNT_EN, err_cnt = 1. After 300 illegal steps, err_cnt = 255.
//  6. Push: hold btn high for 50 cycles, then release.
//     -> One push pulse, 7 cycles after the rising edge. None on release.
//     Assert res mid-CW (after 2 steps) -> no rot_up, outputs 0.

Source files
------------

// File: rtl/rotary_decoder.sv
// Rotary encoder front end: synchronises and debounces A/B/button, decodes Gray-code rotation into pulses.
// Define ROT_ERR_CNT_EN to add the saturating illegal-transition counter on err_cnt.
module rotary_decoder #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 40000,
  parameter int STEPS_PER_PULSE = 4
) (
  input  logic       clk,
  input  logic       res,
  input  logic       enc_a,
  input  logic       enc_b,
  input  logic       enc_btn,
  output logic       rot_up,
  output logic       rot_dn,
`ifdef ROT_ERR_CNT_EN
  output logic       push,
  output logic [7:0] err_cnt
`else
  output logic       push
`endif
);

  localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  // Pin vector layout {btn, a, b}; A/B idle at the 2'b11 detent, button idle low.
  localparam logic [2:0]        PIN_RST = 3'b011;
  localparam logic signed [3:0] ACC_POS = 4'(STEPS_PER_PULSE);
  localparam logic signed [3:0] ACC_NEG = -ACC_POS;

  // Position along the CW cycle 00->01->11->10; a forward difference of 1 is one CW step.
  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  logic [2:0]       sync_p [SYNC_STAGES];
  logic [2:0]       synced;
  logic [2:0]       stable_p1;
  logic [CNT_W-1:0] db_cnt_p1 [3];

  // Stage 0: plain synchroniser chain, no logic between flops
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= PIN_RST;
    end else begin
      sync_p[0] <= {enc_btn, enc_a, enc_b};
      for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
    end
  end

  assign synced = sync_p[SYNC_STAGES-1];

  // Stage 1: independent debounce per pin
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      stable_p1 <= PIN_RST;
      for (int i = 0; i < 3; i++) db_cnt_p1[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (synced[i] == stable_p1[i]) begin
          db_cnt_p1[i] <= '0;
        end else if (db_cnt_p1[i] == CNT_MAX) begin
          stable_p1[i] <= synced[i];
          db_cnt_p1[i] <= '0;
        end else begin
          db_cnt_p1[i] <= db_cnt_p1[i] + CNT_W'(1);
        end
      end
    end
  end

  logic [1:0]        ab_prev_p2;
  logic              btn_prev_p2;
  logic signed [3:0] acc_p2;
  logic signed [3:0] acc_nxt;
  logic [1:0]        step;
  logic              up_nxt;
  logic              dn_nxt;

  always_comb begin
    step    = gray_pos(stable_p1[1:0]) - gray_pos(ab_prev_p2);
    acc_nxt = acc_p2;
    up_nxt  = 1'b0;
    dn_nxt  = 1'b0;
    case (step)
      2'd1:    acc_nxt = acc_p2 + 4'sd1;
      2'd3:    acc_nxt = acc_p2 - 4'sd1;
      2'd2:    acc_nxt = 4'sd0;
      default: acc_nxt = acc_p2;
    endcase
    if (acc_nxt == ACC_POS) begin
      up_nxt  = 1'b1;
      acc_nxt = 4'sd0;
    end else if (acc_nxt == ACC_NEG) begin
      dn_nxt  = 1'b1;
      acc_nxt = 4'sd0;
    end
  end

  // Stage 2: quadrature accumulator and registered pulse outputs
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      ab_prev_p2  <= PIN_RST[1:0];
      btn_prev_p2 <= PIN_RST[2];
      acc_p2      <= 4'sd0;
      rot_up      <= 1'b0;
      rot_dn      <= 1'b0;
      push        <= 1'b0;
    end else begin
      ab_prev_p2  <= stable_p1[1:0];
      btn_prev_p2 <= stable_p1[2];
      acc_p2      <= acc_nxt;
      rot_up      <= up_nxt;
      rot_dn      <= dn_nxt;
      push        <= stable_p1[2] & ~btn_prev_p2;
    end
  end

`ifdef ROT_ERR_CNT_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic illegal_step;
  assign illegal_step = (step == 2'd2);

  always_ff @(posedge clk or posedge res) begin
    if (res) err_cnt <= 8'd0;
    else if (illegal_step) err_cnt <= sat_inc8(err_cnt);
  end
`endif

endmodule

// File: tb/tb_rotary_decoder.sv
// Bench for rotary_decoder: vector table, hand-written latency/reset sequences, random stimulus vs. model.
module tb_rotary_decoder;
  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int SPP  = 4;

  logic clk = 1'b0;
  logic res;
  logic enc_a, enc_b, enc_btn;
  logic rot_up, rot_dn, push;
`ifdef ROT_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  always #5 clk = ~clk;

  rotary_decoder #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .STEPS_PER_PULSE(SPP)) dut (
    .clk(clk), .res(res), .enc_a(enc_a), .enc_b(enc_b), .enc_btn(enc_btn),
`ifdef ROT_ERR_CNT_EN
    .err_cnt(err_cnt),
`endif
    .rot_up(rot_up), .rot_dn(rot_dn), .push(push)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: positions along the CW cycle, indexed by the AB value.
  int         pos_of [4] = '{0, 1, 3, 2};
  logic [2:0] hist [$];
  logic [2:0] m_stable, m_stable_prev;
  int         m_acc, m_err;
  int         e_up, e_dn, e_push;

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < 16; i++) hist.push_back(3'b011);
    m_stable = 3'b011; m_stable_prev = 3'b011;
    m_acc = 0; m_err = 0; e_up = 0; e_dn = 0; e_push = 0;
  endtask

  task automatic model_edge();
    int d;
    logic all_diff;
    if (res) begin
      model_reset();
      return;
    end
    d = (pos_of[m_stable[1:0]] - pos_of[m_stable_prev[1:0]] + 4) % 4;
    e_up = 0; e_dn = 0;
    if (d == 1) m_acc++;
    else if (d == 3) m_acc--;
    else if (d == 2) begin
      m_acc = 0;
      if (m_err < 255) m_err++;
    end
    if (m_acc == SPP) begin e_up = 1; m_acc = 0; end
    else if (m_acc == -SPP) begin e_dn = 1; m_acc = 0; end
    e_push = (m_stable[2] && !m_stable_prev[2]) ? 1 : 0;
    m_stable_prev = m_stable;
    // A debounced bit flips once the synchronised pin has disagreed for DEB consecutive edges.
    hist.push_back({enc_btn, enc_a, enc_b});
    for (int b = 0; b < 3; b++) begin
      all_diff = 1'b1;
      for (int j = 0; j < DEB; j++)
        if (hist[hist.size()-1-SYNC-j][b] == m_stable[b]) all_diff = 1'b0;
      if (all_diff) m_stable[b] = ~m_stable[b];
    end
    if (hist.size() > 32) void'(hist.pop_front());
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("rot_up", int'(rot_up), e_up);
    chk("rot_dn", int'(rot_dn), e_dn);
    chk("push", int'(push), e_push);
    chk("up_dn_together", int'(rot_up & rot_dn), 0);
`ifdef ROT_ERR_CNT_EN
    chk("err_cnt", int'(err_cnt), m_err);
`endif
  endtask

  task automatic hold(input logic [1:0] ab, input logic btn, input int n,
                      output int ups, output int dns, output int pss);
    enc_a = ab[1]; enc_b = ab[0]; enc_btn = btn;
    ups = 0; dns = 0; pss = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      ups += int'(rot_up); dns += int'(rot_dn); pss += int'(push);
    end
  endtask

  // Ticks until the selected pulse (0 = rot_up, 1 = push); -1 if it never comes in 20 cycles.
  task automatic wait_pulse(input int sel, output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (lat < 0 && ((sel == 0) ? rot_up : push)) lat = i;
    end
  endtask

  typedef struct {
    logic [1:0] ab;
    logic       btn;
    int         n;
    int         up;
    int         dn;
    int         ps;
  } vec_t;

  vec_t vecs [$];
  int   u, d, p, lat;

  initial begin
    vecs = '{
      '{2'b10, 1'b0, 10, 0, 0, 0}, '{2'b00, 1'b0, 10, 0, 0, 0},   // CW detent
      '{2'b01, 1'b0, 10, 0, 0, 0}, '{2'b11, 1'b0, 10, 1, 0, 0},
      '{2'b01, 1'b0, 10, 0, 0, 0}, '{2'b00, 1'b0, 10, 0, 0, 0},   // CCW detent
      '{2'b10, 1'b0, 10, 0, 0, 0}, '{2'b11, 1'b0, 10, 0, 1, 0},
      '{2'b10, 1'b0, 10, 0, 0, 0}, '{2'b00, 1'b0, 10, 0, 0, 0},   // half CW then back
      '{2'b10, 1'b0, 10, 0, 0, 0}, '{2'b11, 1'b0, 10, 0, 0, 0},
      '{2'b01, 1'b0,  3, 0, 0, 0}, '{2'b11, 1'b0, 12, 0, 0, 0},   // 3-cycle glitch on A
      '{2'b01, 1'b0,  4, 0, 0, 0}, '{2'b11, 1'b0, 12, 0, 0, 0},   // 4-cycle A low passes, cancels
      '{2'b01, 1'b0,  4, 0, 0, 0}, '{2'b00, 1'b0,  4, 0, 0, 0},   // CCW at minimum hold
      '{2'b10, 1'b0,  4, 0, 0, 0}, '{2'b11, 1'b0, 12, 0, 1, 0},
      '{2'b00, 1'b0, 10, 0, 0, 0}, '{2'b11, 1'b0, 10, 0, 0, 0},   // illegal both ways
      '{2'b11, 1'b1, 50, 0, 0, 1}, '{2'b11, 1'b0, 20, 0, 0, 0}    // button press/release
    };

    // Reset with undefined pins
    res = 1'b1; enc_a = 1'bx; enc_b = 1'bx; enc_btn = 1'bx;
    model_reset();
    #1;
    chk("reset_rot_up", int'(rot_up), 0);
    chk("reset_rot_dn", int'(rot_dn), 0);
    chk("reset_push", int'(push), 0);
    for (int i = 0; i < 3; i++) tick();
    res = 1'b0;
    hold(2'b11, 1'b0, 20, u, d, p);
    chk("idle_pulses", u + d + p, 0);

    foreach (vecs[i]) begin
      hold(vecs[i].ab, vecs[i].btn, vecs[i].n, u, d, p);
      chk($sformatf("vec%0d_up", i), u, vecs[i].up);
      chk($sformatf("vec%0d_dn", i), d, vecs[i].dn);
      chk($sformatf("vec%0d_push", i), p, vecs[i].ps);
    end

    // CW latency from final edge
    hold(2'b10, 1'b0, 10, u, d, p);
    hold(2'b00, 1'b0, 10, u, d, p);
    hold(2'b01, 1'b0, 10, u, d, p);
    enc_a = 1'b1; enc_b = 1'b1;
    wait_pulse(0, lat);
    chk("cw_latency", lat, SYNC + DEB + 1);

    // Push latency, no repeat while held, nothing on release
    enc_btn = 1'b1;
    wait_pulse(1, lat);
    chk("push_latency", lat, SYNC + DEB + 1);
    hold(2'b11, 1'b1, 30, u, d, p);
    chk("push_held", p, 0);
    hold(2'b11, 1'b0, 20, u, d, p);
    chk("push_release", p, 0);

    // Reset mid-CW after two steps
    hold(2'b10, 1'b0, 10, u, d, p);
    hold(2'b00, 1'b0, 10, u, d, p);
    res = 1'b1;
    #2;
    chk("midreset_rot_up", int'(rot_up), 0);
    for (int i = 0; i < 3; i++) tick();
    res = 1'b0;
    hold(2'b00, 1'b0, 10, u, d, p);
    chk("post_reset_illegal_up", u + d, 0);
    hold(2'b01, 1'b0, 10, u, d, p);
    hold(2'b11, 1'b0, 10, u, d, p);
    chk("post_reset_no_up", u, 0);

    // 300 illegal steps
    for (int i = 0; i < 300; i++) begin
      hold((i % 2 == 0) ? 2'b00 : 2'b11, 1'b0, 5, u, d, p);
      chk($sformatf("illegal%0d_pulses", i), u + d, 0);
    end
`ifdef ROT_ERR_CNT_EN
    chk("err_cnt_saturated", int'(err_cnt), 255);
`endif

    // Random segments, occasional reset
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        res = 1'b1;
        tick();
        tick();
        res = 1'b0;
      end
      hold(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), $urandom_range(1, 9), u, d, p);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
